// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and helpers for the stopwatch sequencing controller.
// Imported by the prescaler, the controller and its interface users.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        SAT    = 2'd3
    } sw_state_e;

    function automatic int sw_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int presc_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses and counter-side signals of the stopwatch controller.
// The front end and counter path use master; the controller uses slave.
interface stopwatch_ctrl_if #(
    parameter int COUNT_W = 17
);
    logic               start_stop;
    logic               lap;
    logic               clear;
    logic [COUNT_W-1:0] count_in;
    logic               cnt_en;
    logic               cnt_clr;
    logic [COUNT_W-1:0] lap_value;
    logic               lap_valid;
    logic               overflow;
    logic [1:0]         state;

    modport master (
        output start_stop,
        output lap,
        output clear,
        output count_in,
        input  cnt_en,
        input  cnt_clr,
        input  lap_value,
        input  lap_valid,
        input  overflow,
        input  state
    );

    modport slave (
        input  start_stop,
        input  lap,
        input  clear,
        input  count_in,
        output cnt_en,
        output cnt_clr,
        output lap_value,
        output lap_valid,
        output overflow,
        output state
    );
endinterface

// File: rtl/stopwatch_ctrl_ms_prescaler.sv
// Millisecond prescaler: counts 0..DIV-1 while run is high, holds otherwise.
// tick flags the terminal phase; zero is a synchronous clear.
module ms_prescaler
    import stopwatch_pkg::*;
#(
    parameter int DIV = 10,
    parameter int PW  = presc_w(DIV)
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic zero,
    output logic tick
);

    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] p;

    assign tick = (p == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p <= '0;
        end else if (zero) begin
            p <= '0;
        end else if (run) begin
            p <= tick ? '0 : p + PW'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: run/pause/saturate FSM, 1 ms tick gating,
// counter clear and lap capture. All outputs are registered.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1000,
    parameter int COUNT_W   = 17,
    parameter int MAX_COUNT = 99_999
) (
    input  logic      CLK,
    input  logic      RST,
    stopwatch_ctrl_if.slave bus
);

    localparam int    DIV  = sw_div(CLK_HZ, TICK_HZ);
    localparam longint CMAX = (longint'(1) << COUNT_W) - 1;

    if ((CLK_HZ % TICK_HZ) != 0 || DIV < 4) begin : g_bad_div
        $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be an integer >= 4");
    end

    if (longint'(MAX_COUNT) > CMAX) begin : g_bad_max
        $error("stopwatch_ctrl: MAX_COUNT does not fit in COUNT_W bits");
    end

    sw_state_e          st;
    logic               cnt_en_q;
    logic               cnt_clr_q;
    logic [COUNT_W-1:0] lap_value_q;
    logic               lap_valid_q;
    logic               overflow_q;

    logic ms_tick;
    logic at_max;
    logic presc_run;
    logic presc_zero;

    assign at_max = (bus.count_in == COUNT_W'(MAX_COUNT));

    // A pause landing on the terminal phase keeps p at DIV-1 so the
    // swallowed tick fires right after resume.
    assign presc_run  = (st == RUN) && !bus.clear
                        && !(ms_tick && bus.start_stop);
    assign presc_zero = bus.clear || ((st == IDLE) && bus.start_stop);

    ms_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .CLK  (CLK),
        .RST  (RST),
        .run  (presc_run),
        .zero (presc_zero),
        .tick (ms_tick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st          <= IDLE;
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= 1'b0;
            lap_value_q <= '0;
            lap_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_en_q    <= 1'b0;
            cnt_clr_q   <= bus.clear;
            lap_valid_q <= 1'b0;
            if (bus.clear) begin
                st          <= IDLE;
                overflow_q  <= 1'b0;
                lap_value_q <= '0;
            end else begin
                unique case (st)
                    IDLE: begin
                        if (bus.start_stop) st <= RUN;
                    end
                    RUN: begin
                        if (bus.start_stop) begin
                            st <= PAUSED;
                        end else if (ms_tick) begin
                            if (at_max) begin
                                st         <= SAT;
                                overflow_q <= 1'b1;
                            end else begin
                                cnt_en_q <= 1'b1;
                            end
                        end
                    end
                    PAUSED: begin
                        if (bus.start_stop) st <= RUN;
                    end
                    SAT: begin
                        st <= SAT;
                    end
                    default: begin
                        st <= IDLE;
                    end
                endcase
                if (bus.lap && st != IDLE) begin
                    lap_value_q <= bus.count_in;
                    lap_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.state     = st;
    assign bus.cnt_en    = cnt_en_q;
    assign bus.cnt_clr   = cnt_clr_q;
    assign bus.lap_value = lap_value_q;
    assign bus.lap_valid = lap_valid_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed tables, reset sequence and random
// pulses checked every cycle against a stopwatch reference model.
module tb_stopwatch_ctrl;

    localparam int CW   = 17;
    localparam int DIVV = 10;
    localparam int MAXC = 5;
    localparam int X    = -1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_SAT   = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    stopwatch_ctrl_if #(.COUNT_W(CW)) bus ();

    stopwatch_ctrl #(
        .CLK_HZ    (1000),
        .TICK_HZ   (100),
        .COUNT_W   (CW),
        .MAX_COUNT (MAXC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Millisecond counter the controller drives
    logic [CW-1:0] count;
    always @(posedge CLK or posedge RST) begin
        if (RST)              count <= '0;
        else if (bus.cnt_clr) count <= '0;
        else if (bus.cnt_en)  count <= count + 1'b1;
    end
    assign bus.count_in = count;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: mode, elapsed phase within the current ms, outputs
    int m_mode, m_phase, m_count, m_lval;
    bit m_en, m_clr, m_lvld, m_ovf;

    function automatic void model_reset();
        m_mode = M_IDLE; m_phase = 0; m_count = 0; m_lval = 0;
        m_en = 0; m_clr = 0; m_lvld = 0; m_ovf = 0;
    endfunction

    function automatic void model_step(bit ss, bit lp, bit cl);
        int  cnt_nx;
        bit  ms_done;
        cnt_nx  = m_clr ? 0 : (m_en ? m_count + 1 : m_count);
        ms_done = (m_mode == M_RUN) && (m_phase == DIVV - 1);
        m_clr = cl; m_en = 0; m_lvld = 0;
        if (cl) begin
            m_mode = M_IDLE; m_phase = 0; m_ovf = 0; m_lval = 0;
        end else begin
            if (lp && m_mode != M_IDLE) begin
                m_lval = m_count; m_lvld = 1;
            end
            case (m_mode)
                M_IDLE: if (ss) begin m_mode = M_RUN; m_phase = 0; end
                M_RUN: begin
                    if (ss) begin
                        m_mode = M_PAUSE;
                        if (!ms_done) m_phase++;
                    end else if (ms_done) begin
                        m_phase = 0;
                        if (m_count == MAXC) begin
                            m_mode = M_SAT; m_ovf = 1;
                        end else begin
                            m_en = 1;
                        end
                    end else begin
                        m_phase++;
                    end
                end
                M_PAUSE: if (ss) m_mode = M_RUN;
                default: ;
            endcase
        end
        m_count = cnt_nx;
    endfunction

    task automatic model_check();
        chk("model.state",     int'(bus.state),     m_mode);
        chk("model.cnt_en",    int'(bus.cnt_en),    int'(m_en));
        chk("model.cnt_clr",   int'(bus.cnt_clr),   int'(m_clr));
        chk("model.lap_valid", int'(bus.lap_valid), int'(m_lvld));
        chk("model.lap_value", int'(bus.lap_value), m_lval);
        chk("model.overflow",  int'(bus.overflow),  int'(m_ovf));
        chk("model.count",     int'(count),         m_count);
    endtask

    // Apply pulses for one cycle, advance and compare against the model
    task automatic step(input bit ss, input bit lp, input bit cl);
        bus.start_stop = ss; bus.lap = lp; bus.clear = cl;
        model_step(ss, lp, cl);
        @(posedge CLK); #1;
        bus.start_stop = 0; bus.lap = 0; bus.clear = 0;
        model_check();
    endtask

    typedef struct {
        int cyc;
        bit ss, lp, cl;
        int st, en, clr, cnt, lv, lvd, ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int c, bit ss, bit lp, bit cl, int st,
                                int en, int clr, int cnt, int lv,
                                int lvd, int ovf);
        vec_t r;
        r.cyc = c; r.ss = ss; r.lp = lp; r.cl = cl;
        r.st = st; r.en = en; r.clr = clr; r.cnt = cnt;
        r.lv = lv; r.lvd = lvd; r.ovf = ovf;
        return r;
    endfunction

    task automatic check_row(input string n, input vec_t r);
        string t;
        t = $sformatf("%s@%0d", n, r.cyc);
        if (r.st  != X) chk({t, ".state"},     int'(bus.state),     r.st);
        if (r.en  != X) chk({t, ".cnt_en"},    int'(bus.cnt_en),    r.en);
        if (r.clr != X) chk({t, ".cnt_clr"},   int'(bus.cnt_clr),   r.clr);
        if (r.cnt != X) chk({t, ".count"},     int'(count),         r.cnt);
        if (r.lv  != X) chk({t, ".lap_value"}, int'(bus.lap_value), r.lv);
        if (r.lvd != X) chk({t, ".lap_valid"}, int'(bus.lap_valid), r.lvd);
        if (r.ovf != X) chk({t, ".overflow"},  int'(bus.overflow),  r.ovf);
    endtask

    task automatic run_table(input string n);
        int idx = 0;
        int last = tbl[tbl.size()-1].cyc;
        for (int c = 0; c <= last; c++) begin
            bit ss = 0, lp = 0, cl = 0;
            while (idx < tbl.size() && tbl[idx].cyc == c) begin
                check_row(n, tbl[idx]);
                ss |= tbl[idx].ss; lp |= tbl[idx].lp; cl |= tbl[idx].cl;
                idx++;
            end
            step(ss, lp, cl);
        end
    endtask

    task automatic to_idle();
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    initial begin
        bus.start_stop = 0; bus.lap = 0; bus.clear = 0;
        model_reset();
        #3;
        chk("reset.state",     int'(bus.state),     0);
        chk("reset.cnt_en",    int'(bus.cnt_en),    0);
        chk("reset.cnt_clr",   int'(bus.cnt_clr),   0);
        chk("reset.lap_value", int'(bus.lap_value), 0);
        chk("reset.lap_valid", int'(bus.lap_valid), 0);
        chk("reset.overflow",  int'(bus.overflow),  0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 0;
        step(0, 0, 0);
        step(0, 0, 0);

        // Start, lap, saturation, clear, lap in IDLE
        tbl.delete();
        tbl.push_back(mk( 0, 1,0,0, 0,0,0,0,0,0,0));
        tbl.push_back(mk( 1, 0,0,0, 1,0,X,0,X,X,X));
        tbl.push_back(mk(10, 0,0,0, 1,0,X,0,X,X,X));
        tbl.push_back(mk(11, 0,0,0, 1,1,X,0,X,X,X));
        tbl.push_back(mk(12, 0,0,0, 1,0,X,1,X,X,X));
        tbl.push_back(mk(21, 0,0,0, X,1,X,X,X,X,X));
        tbl.push_back(mk(22, 0,0,0, X,0,X,2,X,X,X));
        tbl.push_back(mk(31, 0,0,0, X,1,X,X,X,X,X));
        tbl.push_back(mk(32, 0,0,0, 1,0,X,3,X,X,X));
        tbl.push_back(mk(33, 0,1,0, X,X,X,3,0,0,X));
        tbl.push_back(mk(34, 0,0,0, X,X,X,X,3,1,X));
        tbl.push_back(mk(35, 0,0,0, X,X,X,X,3,0,X));
        tbl.push_back(mk(41, 0,0,0, X,1,X,X,X,X,X));
        tbl.push_back(mk(51, 0,0,0, X,1,X,X,X,X,X));
        tbl.push_back(mk(52, 0,0,0, 1,0,X,5,X,X,0));
        tbl.push_back(mk(60, 0,0,0, 1,0,X,5,X,X,0));
        tbl.push_back(mk(61, 0,0,0, 3,0,X,5,X,X,1));
        tbl.push_back(mk(62, 1,0,0, 3,0,X,5,X,X,1));
        tbl.push_back(mk(63, 0,0,0, 3,0,X,5,X,X,1));
        tbl.push_back(mk(64, 0,1,0, 3,X,X,X,X,X,X));
        tbl.push_back(mk(65, 0,0,0, 3,X,X,X,5,1,X));
        tbl.push_back(mk(66, 0,0,1, 3,X,0,5,X,X,1));
        tbl.push_back(mk(67, 0,0,0, 0,0,1,X,0,0,0));
        tbl.push_back(mk(68, 0,0,0, 0,X,0,0,X,X,X));
        tbl.push_back(mk(69, 0,1,0, 0,X,X,X,X,X,X));
        tbl.push_back(mk(70, 0,0,0, 0,X,X,X,0,0,X));
        run_table("sat");
        to_idle();

        // Pause/resume, pause on terminal phase, triple coincidence
        tbl.delete();
        tbl.push_back(mk( 0, 1,0,0, 0,X,X,0,X,X,X));
        tbl.push_back(mk(11, 0,0,0, 1,1,X,X,X,X,X));
        tbl.push_back(mk(15, 1,0,0, 1,X,X,X,X,X,X));
        tbl.push_back(mk(16, 0,0,0, 2,0,X,X,X,X,X));
        tbl.push_back(mk(30, 0,0,0, 2,0,X,1,X,X,X));
        tbl.push_back(mk(40, 1,0,0, 2,0,X,X,X,X,X));
        tbl.push_back(mk(41, 0,0,0, 1,0,X,X,X,X,X));
        tbl.push_back(mk(45, 0,0,0, X,0,X,X,X,X,X));
        tbl.push_back(mk(46, 0,0,0, X,1,X,X,X,X,X));
        tbl.push_back(mk(47, 0,0,0, X,0,X,2,X,X,X));
        tbl.push_back(mk(55, 1,0,0, 1,0,X,X,X,X,X));
        tbl.push_back(mk(56, 0,0,0, 2,0,X,2,X,X,X));
        tbl.push_back(mk(60, 1,0,0, 2,X,X,X,X,X,X));
        tbl.push_back(mk(61, 0,0,0, 1,0,X,X,X,X,X));
        tbl.push_back(mk(62, 0,0,0, X,1,X,X,X,X,X));
        tbl.push_back(mk(63, 0,0,0, X,X,X,3,X,X,X));
        tbl.push_back(mk(70, 1,1,1, 1,X,X,X,X,X,X));
        tbl.push_back(mk(71, 0,0,0, 0,0,1,X,0,0,X));
        tbl.push_back(mk(72, 0,0,0, 0,X,0,0,X,X,X));
        run_table("pause");
        to_idle();

        // Asynchronous reset in the middle of RUN, prescaler at phase 6
        step(1, 0, 0);
        repeat (12) step(0, 0, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        chk("rst.pre_lap_value", int'(bus.lap_value), 1);
        #2 RST = 1;
        #1;
        chk("rst.state",     int'(bus.state),     0);
        chk("rst.cnt_en",    int'(bus.cnt_en),    0);
        chk("rst.cnt_clr",   int'(bus.cnt_clr),   0);
        chk("rst.lap_value", int'(bus.lap_value), 0);
        chk("rst.lap_valid", int'(bus.lap_valid), 0);
        chk("rst.overflow",  int'(bus.overflow),  0);
        @(posedge CLK); #1;
        RST = 0;
        model_reset();
        step(1, 0, 0);
        for (int i = 1; i <= 11; i++) begin
            chk($sformatf("rst.cnt_en@%0d", i), int'(bus.cnt_en),
                (i == 11) ? 1 : 0);
            if (i < 11) step(0, 0, 0);
        end
        to_idle();

        // Random pulse streams against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the 17-bit millisecond counter: divides the system clock into a 1 ms tick, gates the counter enable, and clears it on command. It interprets single-cycle button pulses (start/stop, lap, clear) as a stopwatch and captures lap times. It saturates at a configurable maximum. It sits between the debounced button front end and the counter/display path.

## Interface

Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- TICK_HZ, 1000, tick rate.
- DIV = CLK_HZ/TICK_HZ, derived; must be an integer ≥ 4. Elaboration error otherwise.
- COUNT_W, 17, counter width.
- MAX_COUNT, 99_999, terminal count. Must be ≤ 2^COUNT_W − 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high. Also wired directly to the counter's RST.
- start_stop  in  1  single-cycle pulse, synchronous to CLK.
- lap  in  1  single-cycle pulse.
- clear  in  1  single-cycle pulse.
- count_in  in  COUNT_W  current counter value.
- cnt_en  out  COUNT_W-independent, 1  registered tick to the counter's EN; high for exactly one cycle per tick.
- cnt_clr  out  1  registered one-cycle clear pulse, ORed with RST at the counter's RST.
- lap_value  out  COUNT_W  last captured count.
- lap_valid  out  1  one-cycle pulse, high in the cycle lap_value updates.
- overflow  out  1  high while saturated.
- state  out  2  current FSM state, for the display.

## Operation

States:
- IDLE=0, RUN=1, PAUSED=2, SAT=3.

Transitions:
- IDLE: start_stop → RUN.
- RUN: start_stop → PAUSED.
- PAUSED: start_stop → RUN.
- SAT: start_stop is ignored.
- clear in any state → IDLE. Also pulses cnt_clr, zeroes the prescaler, and drops overflow.

Priority when inputs coincide:
- clear > start_stop > lap.
- A lap coincident with start_stop is still captured unless clear is also present.

Prescaler:
- Counts 0..DIV−1 only in RUN.
- Holds its value in PAUSED, so no partial millisecond is lost.
- Zeroed on IDLE→RUN.
- On p == DIV−1: p returns to 0 and cnt_en is set for the next cycle.

Saturation:
- When p == DIV−1 and count_in == MAX_COUNT, cnt_en is suppressed, the next state is SAT, and overflow=1.
- count_in is always settled at the compare, because ticks are at least DIV ≥ 4 cycles apart.

Lap:
- In RUN, PAUSED or SAT, lap registers count_in into lap_value and pulses lap_valid.
- In IDLE, lap is ignored.
- lap_value persists across pause/run and is zeroed only by clear or RST.

Tick vs. start_stop:
- A RUN→PAUSED transition in the same cycle as p == DIV−1 suppresses that tick.
- The prescaler then holds at DIV−1; the tick fires in the first RUN cycle after resume.

## Timing

Reset values:
- state=IDLE, prescaler=0, cnt_en=0, cnt_clr=0, lap_value=0, lap_valid=0, overflow=0.

Start latency (start_stop high in cycle n, from IDLE):
- state=RUN in cycle n+1, with p=0.
- p=DIV−1 in cycle n+DIV.
- cnt_en high in cycle n+DIV+1.
- count_in=1 in cycle n+DIV+2.
- Subsequent cnt_en pulses every DIV cycles.

Other latencies:
- clear in cycle n: cnt_clr high in n+1 only, state=IDLE in n+1, counter reads 0 in n+2.
- lap in cycle n: lap_valid and the new lap_value in n+1.
- All outputs are registered. No combinational input→output path.
- RST mid-operation returns every register to its reset value immediately.

## Structure

Package stopwatch_pkg:
- state enum (IDLE, RUN, PAUSED, SAT).
- DIV computation function.
- Prescaler width = $clog2(DIV).

Sub-module ms_prescaler:
- Ports: CLK, RST, run, zero, tick.
- Holds when run=0; synchronous zero.

stopwatch_ctrl contains:
- FSM.
- Lap register.
- Saturation compare.
- Output registers.

Expected size is roughly 180 lines total.

## Test plan

All scenarios use CLK_HZ=1000, TICK_HZ=100 (DIV=10) and MAX_COUNT=5, with a behavioural counter model attached.

- **Start:** start_stop at cycle 0 → state=1 at cycle 1; cnt_en at cycles 11, 21, 31; count_in=3 at cycle 32.
- **Pause/resume:** start_stop at cycles 0 and 15 (pause), then at 40 (resume) → no cnt_en during 16–40; next cnt_en at cycle 46; count_in=2 afterwards.
- **Saturation:** run to count_in=5 → next compare suppresses cnt_en; state=3, overflow=1; count stays at 5; start_stop is ignored; clear → state=0, overflow=0, count 0.
- **Lap:** lap at count_in=3 → lap_valid for 1 cycle, lap_value=3; lap in IDLE → no lap_valid.
- **Simultaneous inputs:** clear+start_stop+lap in RUN → IDLE, cnt_clr pulse, no lap_valid. start_stop coincident with p=9 → no cnt_en, PAUSED.
- **Mid-run reset:** RST asserted mid-RUN at p=6 → all outputs 0 asynchronously; after release, start_stop gives first cnt_en after a full 10 cycles.
